// File: rtl/fsm_trace_display.sv
// Trace capture/review stage: logs {state, rout} on each FSM state change, then steps through the log.
// Optional TRACE_STATE_DISP_EN: in review, digit 3 shows the stored state nibble.
module fsm_trace_display #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned STATE_W = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [STATE_W-1:0]         state,
  input  logic [DATA_W-1:0]          rout,
  input  logic                       freeze,
  input  logic                       step,
  output logic [27:0]                display,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic                       review,
  output logic                       full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_C  = AW'(DEPTH-1);
`ifdef TRACE_STATE_DISP_EN
  localparam int unsigned ENTRY_W = STATE_W + DATA_W;
`else
  localparam int unsigned ENTRY_W = DATA_W;
`endif

  typedef enum logic {S_CAPTURE, S_REVIEW} mode_e;

  mode_e               mode_q, mode_d;
  logic [STATE_W-1:0]  prev_state_q, prev_state_d;
  logic                first_q, first_d;
  logic                step_q, step_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_idx_q, rd_idx_d;
  logic [AW:0]         count_q, count_d;
  logic [27:0]         display_q, display_d;
  logic [ENTRY_W-1:0]  mem_q [DEPTH];
  logic [ENTRY_W-1:0]  wdata, rd_entry;
  logic                we, capture_ev, full_w;
  logic [15:0]         disp_word;

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  function automatic logic [27:0] seg4(input logic [15:0] w);
    logic [27:0] r;
    r = '1;
    for (int unsigned i = 0; i < 4; i++) r[i*7 +: 7] = hex_seg(w[i*4 +: 4]);
    return r;
  endfunction

  assign full_w = (count_q == DEPTH_C);

`ifdef TRACE_STATE_DISP_EN
  assign wdata = {state, rout};
`else
  assign wdata = rout;
`endif

  always_comb begin
    mode_d       = mode_q;
    prev_state_d = state;
    first_d      = first_q;
    step_d       = step;
    wr_ptr_d     = wr_ptr_q;
    rd_idx_d     = rd_idx_q;
    count_d      = count_q;
    we           = 1'b0;
    rd_entry     = mem_q[rd_idx_q];
    disp_word    = rout;

    capture_ev = (mode_q == S_CAPTURE) && !full_w &&
                 (first_q || (state != prev_state_q));
    if (capture_ev) begin
      we      = 1'b1;
      count_d = count_q + 1'b1;
      first_d = 1'b0;
      // Pointer saturates at the last slot; count alone gates further writes.
      if (wr_ptr_q != LAST_C) wr_ptr_d = wr_ptr_q + 1'b1;
    end

    unique case (mode_q)
      S_CAPTURE: begin
        disp_word = rout;
        if ((count_d == DEPTH_C) || (freeze && (count_d != '0))) begin
          mode_d   = S_REVIEW;
          rd_idx_d = '0;
        end
      end
      S_REVIEW: begin
        if (step && !step_q)
          rd_idx_d = ({1'b0, rd_idx_q} == count_q - 1'b1) ? '0 : rd_idx_q + 1'b1;
`ifdef TRACE_STATE_DISP_EN
        disp_word = {rd_entry[DATA_W +: 4], rd_entry[11:0]};
`else
        disp_word = rd_entry;
`endif
      end
      default: ;
    endcase

    display_d = seg4(disp_word);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q       <= S_CAPTURE;
      prev_state_q <= '0;
      first_q      <= 1'b1;
      step_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_idx_q     <= '0;
      count_q      <= '0;
      display_q    <= '1;
    end else begin
      mode_q       <= mode_d;
      prev_state_q <= prev_state_d;
      first_q      <= first_d;
      step_q       <= step_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_idx_q     <= rd_idx_d;
      count_q      <= count_d;
      display_q    <= display_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[wr_ptr_q] <= wdata;
  end

  assign display = display_q;
  assign count   = count_q;
  assign rd_idx  = rd_idx_q;
  assign review  = (mode_q == S_REVIEW);
  assign full    = full_w;

endmodule

// File: tb/tb_fsm_trace_display.sv
// Directed bench for fsm_trace_display; display expectations flow through a scoreboard queue.
// Honours TRACE_STATE_DISP_EN for the review-mode digit 3 expectation.
module tb_fsm_trace_display;

  logic        clk = 1'b0;
  logic        reset, freeze, step;
  logic [3:0]  state;
  logic [15:0] rout;
  logic [27:0] display;
  logic [4:0]  count;
  logic [3:0]  rd_idx;
  logic        review, full;

  int checks = 0;
  int errors = 0;
  logic [27:0] exp_q [$];
  logic [3:0]  m_state [16];
  logic [15:0] m_rout  [16];
  int          rd_seq  [6] = '{1, 2, 3, 0, 1, 2};

  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clk = ~clk;

  fsm_trace_display #(.DEPTH(16), .DATA_W(16), .STATE_W(4)) dut (
    .clk(clk), .reset(reset), .state(state), .rout(rout), .freeze(freeze), .step(step),
    .display(display), .count(count), .rd_idx(rd_idx), .review(review), .full(full)
  );

  function automatic logic [27:0] seg4(input logic [15:0] w);
    return {SEG[w[15:12]], SEG[w[11:8]], SEG[w[7:4]], SEG[w[3:0]]};
  endfunction

  function automatic logic [27:0] rev_disp(input int idx);
`ifdef TRACE_STATE_DISP_EN
    return {SEG[m_state[idx]], SEG[m_rout[idx][11:8]], SEG[m_rout[idx][7:4]], SEG[m_rout[idx][3:0]]};
`else
    return seg4(m_rout[idx]);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [27:0] exp_disp);
    logic [27:0] e;
    exp_q.push_back(exp_disp);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("display", 32'(display), 32'(e));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(28'hFFFFFFF);
    reset = 1'b0;
  endtask

  initial begin
    int cur;
    reset = 1'b1; freeze = 1'b1; step = 1'b0; state = '0; rout = '0;
    cyc(28'hFFFFFFF);
    cyc(28'hFFFFFFF);
    chk("rst_review_with_freeze", 32'(review), 32'(0));
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_rd_idx", 32'(rd_idx), 32'(0));
    chk("rst_full", 32'(full), 32'(0));
    freeze = 1'b0; reset = 1'b0;

    // Steady state after reset: exactly one capture.
    cyc(28'h8102040);
    chk("t1_count_first", 32'(count), 32'(1));
    for (int i = 0; i < 4; i++) cyc(28'h8102040);
    chk("t1_count_hold", 32'(count), 32'(1));
    chk("t1_review", 32'(review), 32'(0));

    // Four captures, then freeze with step already held.
    do_reset();
    chk("t2_count_rst", 32'(count), 32'(0));
    for (int i = 0; i < 4; i++) begin
      state = 4'(i);
      rout  = 16'(16'h1 << (4 * i));
      m_state[i] = state;
      m_rout[i]  = rout;
      cyc(seg4(rout));
    end
    chk("t2_count4", 32'(count), 32'(4));
    chk("t2_not_review", 32'(review), 32'(0));
    freeze = 1'b1; step = 1'b1;
    cyc(seg4(16'h1000));
    chk("t2_review", 32'(review), 32'(1));
    chk("t2_count_frozen", 32'(count), 32'(4));
    chk("t2_rd0", 32'(rd_idx), 32'(0));
    freeze = 1'b0;
    cyc(rev_disp(0));
    chk("t2_held_step_rd", 32'(rd_idx), 32'(0));
    cyc(rev_disp(0));
    chk("t2_held_step_rd2", 32'(rd_idx), 32'(0));
    step = 1'b0;
    cyc(rev_disp(0));

    // Step pulses, 3 cycles high each: one advance per pulse, wrap after count-1.
    cur = 0;
    for (int p = 0; p < 6; p++) begin
      step = 1'b1;
      for (int k = 0; k < 3; k++) begin
        cyc(rev_disp(k == 0 ? cur : rd_seq[p]));
        chk("t3_rd_idx", 32'(rd_idx), 32'(rd_seq[p]));
      end
      step = 1'b0;
      for (int k = 0; k < 2; k++) cyc(rev_disp(rd_seq[p]));
      cur = rd_seq[p];
    end

    // Reset out of REVIEW with rd_idx = 2.
    reset = 1'b1;
    cyc(28'hFFFFFFF);
    chk("t6_review", 32'(review), 32'(0));
    chk("t6_count", 32'(count), 32'(0));
    chk("t6_rd_idx", 32'(rd_idx), 32'(0));
    chk("t6_full", 32'(full), 32'(0));
    reset = 1'b0;

    // State changes every cycle: fills at the 16th capture, later changes ignored.
    for (int i = 0; i < 20; i++) begin
      state = 4'(i);
      rout  = 16'(i * 16'h0111 + 16'h1);
      if (i < 16) begin
        m_state[i] = state;
        m_rout[i]  = rout;
      end
      cyc((i < 16) ? seg4(rout) : rev_disp(0));
      if (i == 14) begin
        chk("t4_count15", 32'(count), 32'(15));
        chk("t4_not_full", 32'(full), 32'(0));
        chk("t4_not_review", 32'(review), 32'(0));
      end
      if (i == 15) begin
        chk("t4_count16", 32'(count), 32'(16));
        chk("t4_full", 32'(full), 32'(1));
        chk("t4_review", 32'(review), 32'(1));
      end
    end
    chk("t4_count_after", 32'(count), 32'(16));
    chk("t4_rd0", 32'(rd_idx), 32'(0));

    // Freeze coincident with the first capture.
    do_reset();
    state = 4'h5; rout = 16'hABCD; freeze = 1'b1;
    m_state[0] = state; m_rout[0] = rout;
    cyc(seg4(16'hABCD));
    chk("t5_review", 32'(review), 32'(1));
    chk("t5_count", 32'(count), 32'(1));
    freeze = 1'b0;
    cyc(rev_disp(0));
    step = 1'b1;
    cyc(rev_disp(0));
    chk("t5_rd_wrap_single", 32'(rd_idx), 32'(0));
    step = 1'b0;
    cyc(rev_disp(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
